// File: rtl/gs232c_btb_pkg.sv
// Shared types for the BTB init/flush controller.
// State encoding and index width used by the controller and its counter.
package gs232c_btb_pkg;

   localparam int IDX_W = 8;

   typedef logic [IDX_W-1:0] idx_t;

   typedef enum logic {
      IDLE = 1'b0,
      INIT = 1'b1
   } init_state_e;

   function automatic idx_t sat_inc(input idx_t v);
      return (v == '1) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/gs232c_sat_cnt.sv
// 8-bit saturating event counter with async reset and sync clear.
// Holds at all-ones once reached.
module gs232c_sat_cnt
   import gs232c_btb_pkg::*;
(
   input  logic clock,
   input  logic reset,
   input  logic inc,
   input  logic clr,
   output idx_t value
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         value <= '0;
      end else if (clr) begin
         value <= '0;
      end else if (inc) begin
         value <= sat_inc(value);
      end
   end

endmodule

// File: rtl/gs232c_btb_init_ctrl.sv
// BTB table init sweep controller; optional flush via GS232C_BTB_FLUSH_EN.
// Gates pr-stage updates during a sweep and counts the ones dropped.
module gs232c_btb_init_ctrl
   import gs232c_btb_pkg::*;
#(
   parameter logic [IDX_W-1:0] INIT_LAST = 8'hFF
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flush_req,
   input  logic             pr_valid_in,
   input  logic             pr_cancel_in,
   output logic             raminit_valid,
   output logic [IDX_W-1:0] raminit_index,
   output logic             pr_valid_out,
   output logic             pr_cancel_out,
   output logic             init_busy,
   output logic             init_done,
   output logic [IDX_W-1:0] drop_cnt
);

   init_state_e state_q;
   init_state_e state_d;
   idx_t        idx_q;
   idx_t        idx_d;
   logic        done_q;
   logic        done_d;
   logic        flush;
   logic        sweep;
   logic        drop_inc;

`ifdef GS232C_BTB_FLUSH_EN
   assign flush = flush_req;
`else
   logic unused_flush;
   assign unused_flush = flush_req;
   assign flush = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      done_d  = 1'b0;
      unique case (state_q)
         INIT: begin
            if (flush) begin
               idx_d = '0;
            end else if (idx_q == INIT_LAST) begin
               state_d = IDLE;
               idx_d   = '0;
               done_d  = 1'b1;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         IDLE: begin
            if (flush) begin
               state_d = INIT;
               idx_d   = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         done_q  <= done_d;
      end
   end

   assign sweep         = (state_q == INIT);
   assign raminit_valid = sweep;
   assign init_busy     = sweep;
   assign raminit_index = idx_q;
   assign init_done     = done_q;

   // Updates arriving mid-sweep would race the clear, so drop them.
   assign pr_valid_out  = pr_valid_in & ~sweep;
   assign pr_cancel_out = pr_cancel_in & ~sweep;
   assign drop_inc      = sweep & (pr_valid_in | pr_cancel_in);

   gs232c_sat_cnt u_drop_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (drop_inc),
      .clr   (1'b0),
      .value (drop_cnt)
   );

endmodule

// File: tb/tb_gs232c_btb_init_ctrl.sv
// Self-checking bench for gs232c_btb_init_ctrl (GS232C_BTB_FLUSH_EN aware).
// Model tracks sweep start cycle; outputs derive from elapsed cycles.
module tb_gs232c_btb_init_ctrl;

   localparam int LAST = 255;
`ifdef GS232C_BTB_FLUSH_EN
   localparam bit FLUSH_EN = 1'b1;
`else
   localparam bit FLUSH_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       flush_req = 1'b0;
   logic       pr_valid_in = 1'b0;
   logic       pr_cancel_in = 1'b0;
   logic       raminit_valid;
   logic [7:0] raminit_index;
   logic       pr_valid_out;
   logic       pr_cancel_out;
   logic       init_busy;
   logic       init_done;
   logic [7:0] drop_cnt;

   gs232c_btb_init_ctrl dut (
      .clock         (clock),
      .reset         (reset),
      .flush_req     (flush_req),
      .pr_valid_in   (pr_valid_in),
      .pr_cancel_in  (pr_cancel_in),
      .raminit_valid (raminit_valid),
      .raminit_index (raminit_index),
      .pr_valid_out  (pr_valid_out),
      .pr_cancel_out (pr_cancel_out),
      .init_busy     (init_busy),
      .init_done     (init_done),
      .drop_cnt      (drop_cnt)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;
   int vcnt = 0;
   int dcnt = 0;

   // n: cycles since reset; t0: cycle the current sweep began
   int n = 0;
   int t0 = 0;
   int drops = 0;

   always @(posedge clock or posedge reset) begin
      if (reset) begin
         n = 0;
         t0 = 0;
         drops = 0;
      end else begin
         if ((n - t0) <= LAST && (pr_valid_in || pr_cancel_in) && drops < 255)
            drops++;
         n++;
         if (FLUSH_EN && flush_req)
            t0 = n;
      end
   end

   always @(negedge clock) begin
      int         age;
      bit         busy;
      logic [20:0] got;
      logic [20:0] exp;
      age  = n - t0;
      busy = (age <= LAST);
      exp  = {busy, busy, (age == LAST + 1),
              pr_valid_in & ~busy, pr_cancel_in & ~busy,
              busy ? 8'(age) : 8'd0, 8'(drops)};
      got  = {raminit_valid, init_busy, init_done,
              pr_valid_out, pr_cancel_out, raminit_index, drop_cnt};
      tests++;
      if (got !== exp) begin
         fails++;
         if (fails <= 20)
            $display("FAIL cycle_cmp t=%0t got=%h exp=%h", $time, got, exp);
      end
      if (!reset) begin
         if (raminit_valid) vcnt++;
         if (init_done) dcnt++;
      end
   end

   task automatic chk(input string name, input int got, input int exp);
      tests++;
      if (got != exp) begin
         fails++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic wait_done(input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         if (init_done) break;
      end
      if (!init_done) chk("timeout_done", 0, 1);
   endtask

   task automatic wait_idx(input int v, input int lim);
      for (int i = 0; i < lim; i++) begin
         @(negedge clock);
         if (raminit_valid && raminit_index == 8'(v)) break;
      end
      if (!(raminit_valid && raminit_index == 8'(v)))
         chk("timeout_idx", 0, 1);
   endtask

   task automatic pulse_flush();
      #1 flush_req = 1'b1;
      @(posedge clock);
      #1 flush_req = 1'b0;
   endtask

   initial begin
      repeat (2) @(negedge clock);
      chk("rst_idx", raminit_index, 0);
      chk("rst_valid", raminit_valid, 1);
      chk("rst_busy", init_busy, 1);
      chk("rst_done", init_done, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      vcnt = 0;
      dcnt = 0;
      @(negedge clock);
      chk("idx_after_rel", raminit_index, 0);
      @(negedge clock);
      chk("first_edge_idx", raminit_index, 1);
      wait_done(300);
      chk("sweep_len", vcnt, 256);
      chk("drop_zero", drop_cnt, 0);
      repeat (3) @(negedge clock);
      chk("done_once", dcnt, 1);

      #1 reset = 1'b1;
      pr_valid_in = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      @(negedge clock);
      chk("pv_gated", pr_valid_out, 0);
      wait_done(300);
      chk("pv_first_idle", pr_valid_out, 1);
      chk("drop_sat", drop_cnt, 255);
      #1 pr_valid_in = 1'b0;
      pr_cancel_in = 1'b1;
      @(negedge clock);
      chk("pc_idle_pass", pr_cancel_out, 1);
      #1 pr_cancel_in = 1'b0;

`ifdef GS232C_BTB_FLUSH_EN
      pulse_flush();
      vcnt = 0;
      dcnt = 0;
      @(negedge clock);
      chk("flush_idle_idx", raminit_index, 0);
      chk("flush_idle_valid", raminit_valid, 1);
      wait_done(300);
      chk("flush_sweep_len", vcnt, 256);
      chk("flush_done_cnt", dcnt, 1);
      chk("drop_kept", drop_cnt, 255);

      pulse_flush();
      dcnt = 0;
      wait_idx(100, 300);
      pulse_flush();
      chk("abort_no_done", dcnt, 0);
      vcnt = 0;
      @(negedge clock);
      chk("flush100_idx", raminit_index, 0);
      wait_done(300);
      chk("restart_len", vcnt, 256);
      chk("restart_done", dcnt, 1);

      pulse_flush();
      dcnt = 0;
      wait_idx(255, 300);
      pulse_flush();
      @(negedge clock);
      chk("flush_last_idx", raminit_index, 0);
      chk("flush_last_nodone", init_done, 0);
      wait_done(300);
      chk("flush_last_done", dcnt, 1);
`else
      vcnt = 0;
      dcnt = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clock);
         #1 flush_req = ~flush_req;
      end
      @(negedge clock);
      #1 flush_req = 1'b0;
      repeat (4) @(negedge clock);
      chk("noflush_valid", vcnt, 0);
      chk("noflush_done", dcnt, 0);
`endif

      #1 reset = 1'b1;
      @(posedge clock);
      #1 reset = 1'b0;
      pr_valid_in = 1'b1;
      wait_idx(37, 100);
      chk("drop_pre_rst", drop_cnt, 37);
      #1 reset = 1'b1;
      #1;
      chk("async_idx", raminit_index, 0);
      chk("async_valid", raminit_valid, 1);
      chk("async_busy", init_busy, 1);
      chk("async_done", init_done, 0);
      chk("async_drop", drop_cnt, 0);
      @(posedge clock);
      #1 reset = 1'b0;
      pr_valid_in = 1'b0;
      wait_done(300);
      repeat (2) @(negedge clock);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
